// File: rtl/gpu_prim_pkg.sv
// Shared command/primitive encodings, sequencer state type and GSR layout
// for the triangle primitive sequencer.
package gpu_prim_pkg;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_BEGIN    = 3'd1;
    localparam logic [2:0] CMD_VERTEX   = 3'd2;
    localparam logic [2:0] CMD_END      = 3'd3;
    localparam logic [2:0] CMD_SETCOLOR = 3'd4;

    localparam logic [1:0] PRIM_LIST  = 2'd0;
    localparam logic [1:0] PRIM_STRIP = 2'd1;
    localparam logic [1:0] PRIM_FAN   = 2'd2;

    // GSR = {prim_type, color}; prim_type occupies the top GSR_PRIM_BITS bits
    localparam int GSR_PRIM_BITS = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT_GPU
    } seq_state_t;

    // Reserved primitive type 3 behaves as a triangle list
    function automatic logic [1:0] norm_prim(input logic [1:0] p);
        return (p == 2'd3) ? PRIM_LIST : p;
    endfunction

endpackage

// File: rtl/prim_vertex_window.sv
// Three-slot vertex window with LIST/STRIP/FAN update rules; reports the
// triangle completed by the current push before the slots update.
module prim_vertex_window
    import gpu_prim_pkg::*;
#(
    parameter int VTX_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [1:0]       prim_type,
    input  logic [VTX_W-1:0] vertex,
    output logic             tri_ready,
    output logic [VTX_W-1:0] tri_v1,
    output logic [VTX_W-1:0] tri_v2,
    output logic [VTX_W-1:0] tri_v3,
    output logic [1:0]       count
);

    logic [VTX_W-1:0] slot1, slot2, slot3;
    logic [VTX_W-1:0] nxt1, nxt2, nxt3;
    logic [1:0]       nxt_count;

    // count==3 only happens for STRIP/FAN; LIST wraps back to 0 on its third vertex
    always_comb begin
        nxt1      = slot1;
        nxt2      = slot2;
        nxt3      = slot3;
        nxt_count = count;
        tri_ready = 1'b0;
        tri_v1    = slot1;
        tri_v2    = slot2;
        tri_v3    = vertex;
        if (push) begin
            if (count == 2'd3) begin
                tri_ready = 1'b1;
                nxt3      = vertex;
                nxt2      = slot3;
                tri_v2    = slot3;
                if (prim_type != PRIM_FAN) begin
                    nxt1   = slot2;
                    tri_v1 = slot2;
                end
            end else begin
                case (count)
                    2'd0:    nxt1 = vertex;
                    2'd1:    nxt2 = vertex;
                    default: nxt3 = vertex;
                endcase
                nxt_count = count + 2'd1;
                if (count == 2'd2) begin
                    tri_ready = 1'b1;
                    if (prim_type == PRIM_LIST) begin
                        nxt_count = 2'd0;
                    end
                end
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1 <= '0;
            slot2 <= '0;
            slot3 <= '0;
            count <= 2'd0;
        end else if (clear) begin
            slot1 <= '0;
            slot2 <= '0;
            slot3 <= '0;
            count <= 2'd0;
        end else begin
            slot1 <= nxt1;
            slot2 <= nxt2;
            slot3 <= nxt3;
            count <= nxt_count;
        end
    end

endmodule

// File: rtl/gpu_prim_sequencer.sv
// Assembles BEGIN/VERTEX/END/SETCOLOR commands into triangles for the GPU stage.
// Optional PRIM_SEQ_CULL_DEGENERATE_EN drops triangles with two identical vertices.
module gpu_prim_sequencer
    import gpu_prim_pkg::*;
#(
    parameter int VTX_W = 30,
    parameter int GSR_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET_N,
    input  logic             I_LOCK,
    input  logic             I_Valid,
    input  logic [2:0]       I_Cmd,
    input  logic [1:0]       I_PrimType,
    input  logic [VTX_W-1:0] I_Vertex,
    input  logic [GSR_W-GSR_PRIM_BITS-1:0] I_Color,
    input  logic             I_GPUStallSignal,
    output logic             O_Stall,
    output logic [VTX_W-1:0] O_VertexV1,
    output logic [VTX_W-1:0] O_VertexV2,
    output logic [VTX_W-1:0] O_VertexV3,
    output logic [GSR_W-1:0] O_GSRValue,
    output logic             O_GSRValue_Valid,
    output logic [CNT_W-1:0] O_PrimCount,
    output logic             O_ProtoErr
);

    seq_state_t state, next_state;
    logic       stall_q;
    logic [1:0] prim_type_q;
    logic [GSR_W-GSR_PRIM_BITS-1:0] color_q;
    logic [VTX_W-1:0] held_v1, held_v2, held_v3;
    logic [GSR_W-1:0] held_gsr;

    logic accept, cmd_begin, cmd_vertex, cmd_end, cmd_setcolor;
    logic win_push, win_clear, win_ready, partial, degenerate;
    logic emit_now, emit_held, capture_held, set_err;
    logic [VTX_W-1:0] tri_v1, tri_v2, tri_v3;
    logic [1:0] win_count;

    prim_vertex_window #(.VTX_W(VTX_W)) u_window (
        .clk       (I_CLOCK),
        .rst_n     (I_RESET_N),
        .clear     (win_clear),
        .push      (win_push),
        .prim_type (prim_type_q),
        .vertex    (I_Vertex),
        .tri_ready (win_ready),
        .tri_v1    (tri_v1),
        .tri_v2    (tri_v2),
        .tri_v3    (tri_v3),
        .count     (win_count)
    );

    always_comb begin
        accept       = I_Valid && !stall_q && I_LOCK;
        cmd_begin    = accept && (I_Cmd == CMD_BEGIN);
        cmd_vertex   = accept && (I_Cmd == CMD_VERTEX);
        cmd_end      = accept && (I_Cmd == CMD_END);
        cmd_setcolor = accept && (I_Cmd == CMD_SETCOLOR);
        win_push     = cmd_vertex && (state == ACTIVE);
        win_clear    = !I_LOCK || cmd_begin;
        partial      = (prim_type_q == PRIM_LIST) ? (win_count == 2'd1 || win_count == 2'd2)
                                                  : (win_count != 2'd3);
`ifdef PRIM_SEQ_CULL_DEGENERATE_EN
        degenerate   = (tri_v1 == tri_v2) || (tri_v1 == tri_v3) || (tri_v2 == tri_v3);
`else
        degenerate   = 1'b0;
`endif
        next_state   = state;
        set_err      = 1'b0;
        emit_now     = 1'b0;
        emit_held    = 1'b0;
        capture_held = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_begin) begin
                    next_state = ACTIVE;
                end else if (cmd_vertex || cmd_end) begin
                    set_err = 1'b1;
                end
            end
            ACTIVE: begin
                if (cmd_begin || cmd_end) begin
                    set_err = partial;
                    if (cmd_end) begin
                        next_state = IDLE;
                    end
                end else if (win_ready && !degenerate) begin
                    if (I_GPUStallSignal) begin
                        capture_held = 1'b1;
                        next_state   = WAIT_GPU;
                    end else begin
                        emit_now = 1'b1;
                    end
                end
            end
            WAIT_GPU: begin
                if (!I_GPUStallSignal) begin
                    emit_held  = 1'b1;
                    next_state = ACTIVE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Lock low abandons everything, including a triangle waiting on the GPU
        if (!I_LOCK) begin
            next_state = IDLE;
            emit_held  = 1'b0;
        end
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state            <= IDLE;
            stall_q          <= 1'b0;
            prim_type_q      <= PRIM_LIST;
            color_q          <= '0;
            held_v1          <= '0;
            held_v2          <= '0;
            held_v3          <= '0;
            held_gsr         <= '0;
            O_VertexV1       <= '0;
            O_VertexV2       <= '0;
            O_VertexV3       <= '0;
            O_GSRValue       <= '0;
            O_GSRValue_Valid <= 1'b0;
            O_PrimCount      <= '0;
            O_ProtoErr       <= 1'b0;
        end else begin
            state            <= next_state;
            stall_q          <= (next_state == WAIT_GPU);
            O_GSRValue_Valid <= emit_now || emit_held;
            if (emit_now || emit_held) begin
                O_PrimCount <= O_PrimCount + CNT_W'(1);
            end
            if (set_err) begin
                O_ProtoErr <= 1'b1;
            end
            if (!I_LOCK) begin
                prim_type_q <= PRIM_LIST;
                color_q     <= '0;
                held_v1     <= '0;
                held_v2     <= '0;
                held_v3     <= '0;
                held_gsr    <= '0;
                O_VertexV1  <= '0;
                O_VertexV2  <= '0;
                O_VertexV3  <= '0;
                O_GSRValue  <= '0;
            end else begin
                if (cmd_begin) begin
                    prim_type_q <= norm_prim(I_PrimType);
                end
                if (cmd_setcolor) begin
                    color_q <= I_Color;
                end
                if (capture_held) begin
                    held_v1  <= tri_v1;
                    held_v2  <= tri_v2;
                    held_v3  <= tri_v3;
                    held_gsr <= {prim_type_q, color_q};
                end
                if (emit_now) begin
                    O_VertexV1 <= tri_v1;
                    O_VertexV2 <= tri_v2;
                    O_VertexV3 <= tri_v3;
                    O_GSRValue <= {prim_type_q, color_q};
                end else if (emit_held) begin
                    O_VertexV1 <= held_v1;
                    O_VertexV2 <= held_v2;
                    O_VertexV3 <= held_v3;
                    O_GSRValue <= held_gsr;
                end
            end
        end
    end

    assign O_Stall = stall_q;

endmodule
